// File: rtl/cpu_ctrl_multicycle.sv
// cpu_ctrl_multicycle
//   Moore-style control unit for a multicycle CPU datapath. Decodes OPCODE/FUNCT
//   from the instruction register and drives one datapath step per state.
//   Memory reads are stretched by MEM_WAIT extra cycles using a wait counter.
//   Undefined instructions trap into a sticky HALT state that only reset leaves.
//
// Ports
//   clk, reset               clock (rising edge), async active-low reset
//   OPCODE, FUNCT, ZERO      IR[31:26], IR[5:0], ULA zero flag
//   PC_w .. REG_w            datapath write strobes
//   IorD, ULA_srcA/srcB/op   memory address and ULA operand/operation selects
//   M_WREG, MemtoReg, PC_src register-bank and PC source selects
//   state, illegal           debug state code, undefined-instruction flag
//
// state  | meaning
// RESET  | one idle cycle after reset release
// FETCH  | read instruction at PC, PC <= PC+4 on last wait cycle
// DECODE | load A/B, precompute branch target into ALUOut
// EXEC_R | R-type add
// WB_R   | write ALUOut to rd
// EXEC_I | addi
// WB_I   | write ALUOut to rt
// ADDR   | effective address for lw/sw
// MEM_RD | data read at ALUOut, load MDR on last wait cycle
// WB_MEM | write MDR to rt
// MEM_WR | single-cycle store
// BRANCH | beq compare, PC <= ALUOut when ZERO
// JUMP   | PC <= jump target
// HALT   | undefined instruction, sticky until reset

module cpu_ctrl_multicycle #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       A_w,
  output logic       B_w,
  output logic       ALUOut_w,
  output logic       MDR_w,
  output logic       REG_w,
  output logic       IorD,
  output logic       ULA_srcA,
  output logic [1:0] ULA_srcB,
  output logic [2:0] ULA_op,
  output logic [1:0] M_WREG,
  output logic       MemtoReg,
  output logic [1:0] PC_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(MEM_WAIT);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Last memory wait cycle: data is valid when the counter reaches MEM_WAIT.
  logic mem_done;
  assign mem_done = (cnt_q == WAIT_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    PC_w     = 1'b0;
    MEM_w    = 1'b0;
    IR_w     = 1'b0;
    A_w      = 1'b0;
    B_w      = 1'b0;
    ALUOut_w = 1'b0;
    MDR_w    = 1'b0;
    REG_w    = 1'b0;
    IorD     = 1'b0;
    ULA_srcA = 1'b0;
    ULA_srcB = 2'b00;
    ULA_op   = OP_PASS;
    M_WREG   = 2'b00;
    MemtoReg = 1'b0;
    PC_src   = 2'b00;
    illegal  = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        ULA_srcB = 2'b01;
        ULA_op   = OP_ADD;
        if (mem_done) begin
          IR_w    = 1'b1;
          PC_w    = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        A_w      = 1'b1;
        B_w      = 1'b1;
        ALUOut_w = 1'b1;
        ULA_srcB = 2'b11;
        ULA_op   = OP_ADD;
        if (OPCODE == OP_RTYPE && FUNCT == FN_ADD) state_d = S_EXEC_R;
        else if (OPCODE == OP_ADDI)                state_d = S_EXEC_I;
        else if (OPCODE == OP_LW || OPCODE == OP_SW) state_d = S_ADDR;
        else if (OPCODE == OP_BEQ)                 state_d = S_BRANCH;
        else if (OPCODE == OP_J)                   state_d = S_JUMP;
        else                                       state_d = S_HALT;
      end
      S_EXEC_R: begin
        ULA_srcA = 1'b1;
        ULA_op   = OP_ADD;
        ALUOut_w = 1'b1;
        state_d  = S_WB_R;
      end
      S_WB_R: begin
        REG_w   = 1'b1;
        M_WREG  = 2'b01;
        state_d = S_FETCH;
      end
      S_EXEC_I: begin
        ULA_srcA = 1'b1;
        ULA_srcB = 2'b10;
        ULA_op   = OP_ADD;
        ALUOut_w = 1'b1;
        state_d  = S_WB_I;
      end
      S_WB_I: begin
        REG_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        ULA_srcA = 1'b1;
        ULA_srcB = 2'b10;
        ULA_op   = OP_ADD;
        ALUOut_w = 1'b1;
        // IR is stable here; anything other than lw/sw would mean it changed.
        if (OPCODE == OP_LW)      state_d = S_MEM_RD;
        else if (OPCODE == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_HALT;
      end
      S_MEM_RD: begin
        IorD = 1'b1;
        if (mem_done) begin
          MDR_w   = 1'b1;
          state_d = S_WB_MEM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB_MEM: begin
        REG_w    = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        IorD    = 1'b1;
        MEM_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ULA_srcA = 1'b1;
        ULA_op   = OP_SUB;
        PC_src   = 2'b01;
        PC_w     = ZERO;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PC_src  = 2'b10;
        PC_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        illegal = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_ctrl_multicycle.sv
// Bench for cpu_ctrl_multicycle: one instance with MEM_WAIT=1 and one with
// MEM_WAIT=0. Stimulus pushes per-cycle expected output vectors into a queue
// per instance; monitors pop and compare on the falling clock edge.
module tb_cpu_ctrl_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {state, PC_w, MEM_w, IR_w, A_w, B_w, ALUOut_w, MDR_w, REG_w,
  //                 IorD, srcA, srcB[1:0], op[2:0], M_WREG[1:0], MemtoReg, PC_src[1:0], illegal}
  localparam logic [24:0] E_RST  = {4'd0,  8'b0000_0000, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_F    = {4'd1,  8'b0000_0000, 1'b0, 1'b0, 2'b01, 3'b001, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_FF   = {4'd1,  8'b1010_0000, 1'b0, 1'b0, 2'b01, 3'b001, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_DEC  = {4'd2,  8'b0001_1100, 1'b0, 1'b0, 2'b11, 3'b001, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_EXR  = {4'd3,  8'b0000_0100, 1'b0, 1'b1, 2'b00, 3'b001, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_WBR  = {4'd4,  8'b0000_0001, 1'b0, 1'b0, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_EXI  = {4'd5,  8'b0000_0100, 1'b0, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_WBI  = {4'd6,  8'b0000_0001, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_ADR  = {4'd7,  8'b0000_0100, 1'b0, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_MRD  = {4'd8,  8'b0000_0000, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_MRDF = {4'd8,  8'b0000_0010, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_WBM  = {4'd9,  8'b0000_0001, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1, 2'b00, 1'b0};
  localparam logic [24:0] E_MWR  = {4'd10, 8'b0100_0000, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 1'b0};
  localparam logic [24:0] E_BR1  = {4'd11, 8'b1000_0000, 1'b0, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0, 2'b01, 1'b0};
  localparam logic [24:0] E_BR0  = {4'd11, 8'b0000_0000, 1'b0, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0, 2'b01, 1'b0};
  localparam logic [24:0] E_JMP  = {4'd12, 8'b1000_0000, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b10, 1'b0};
  localparam logic [24:0] E_HLT  = {4'd15, 8'b0000_0000, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00, 1'b1};

  // Instance with MEM_WAIT = 1
  logic       rst1, zero1;
  logic [5:0] op1, fn1;
  logic       pcw1, memw1, irw1, aw1, bw1, alw1, mdrw1, regw1, iord1, srca1, m2r1, ill1;
  logic [1:0] srcb1, mw1, pcs1;
  logic [2:0] uop1;
  logic [3:0] st1;

  cpu_ctrl_multicycle #(.MEM_WAIT(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .reset(rst1), .OPCODE(op1), .FUNCT(fn1), .ZERO(zero1),
    .PC_w(pcw1), .MEM_w(memw1), .IR_w(irw1), .A_w(aw1), .B_w(bw1),
    .ALUOut_w(alw1), .MDR_w(mdrw1), .REG_w(regw1), .IorD(iord1),
    .ULA_srcA(srca1), .ULA_srcB(srcb1), .ULA_op(uop1), .M_WREG(mw1),
    .MemtoReg(m2r1), .PC_src(pcs1), .state(st1), .illegal(ill1)
  );

  // Instance with MEM_WAIT = 0
  logic       rst0, zero0;
  logic [5:0] op0, fn0;
  logic       pcw0, memw0, irw0, aw0, bw0, alw0, mdrw0, regw0, iord0, srca0, m2r0, ill0;
  logic [1:0] srcb0, mw0, pcs0;
  logic [2:0] uop0;
  logic [3:0] st0;

  cpu_ctrl_multicycle #(.MEM_WAIT(0), .CNT_W(3)) u_dut0 (
    .clk(clk), .reset(rst0), .OPCODE(op0), .FUNCT(fn0), .ZERO(zero0),
    .PC_w(pcw0), .MEM_w(memw0), .IR_w(irw0), .A_w(aw0), .B_w(bw0),
    .ALUOut_w(alw0), .MDR_w(mdrw0), .REG_w(regw0), .IorD(iord0),
    .ULA_srcA(srca0), .ULA_srcB(srcb0), .ULA_op(uop0), .M_WREG(mw0),
    .MemtoReg(m2r0), .PC_src(pcs0), .state(st0), .illegal(ill0)
  );

  logic [24:0] obs1, obs0;
  assign obs1 = {st1, pcw1, memw1, irw1, aw1, bw1, alw1, mdrw1, regw1,
                 iord1, srca1, srcb1, uop1, mw1, m2r1, pcs1, ill1};
  assign obs0 = {st0, pcw0, memw0, irw0, aw0, bw0, alw0, mdrw0, regw0,
                 iord0, srca0, srcb0, uop0, mw0, m2r0, pcs0, ill0};

  typedef struct {
    logic [24:0] v;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      n_tests++;
      if (obs1 !== e.v) begin
        n_fail++;
        $display("FAIL w1 %s: got %h expected %h", e.name, obs1, e.v);
      end
    end
    if (q0.size() > 0) begin
      e = q0.pop_front();
      n_tests++;
      if (obs0 !== e.v) begin
        n_fail++;
        $display("FAIL w0 %s: got %h expected %h", e.name, obs0, e.v);
      end
    end
  end

  task automatic p1(input logic [24:0] v, input string name);
    exp_t e;
    e.v = v; e.name = name;
    q1.push_back(e);
  endtask

  task automatic p0(input logic [24:0] v, input string name);
    exp_t e;
    e.v = v; e.name = name;
    q0.push_back(e);
  endtask

  // Returns at posedge+1 of the first cycle with nothing left to check.
  task automatic drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (q1.size() == 0 && q0.size() == 0) break;
    end
    if (k == 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout %s: queues still hold %0d/%0d entries", name, q1.size(), q0.size());
      q1.delete();
      q0.delete();
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset1_cycle(input string name);
    rst1 = 1'b0;
    #1;
    chk({name, "_async"}, {3'b0, ill1, st1}, 8'h00);
    p1(E_RST, {name, "_held"});
    drain(name);
    rst1 = 1'b1;
    p1(E_RST, {name, "_cycle0"});
    drain(name);
  endtask

  initial begin
    rst1 = 1'b0; rst0 = 1'b0;
    op1 = 6'h00; fn1 = 6'h20; zero1 = 1'b0;
    op0 = 6'h02; fn0 = 6'h00; zero0 = 1'b0;
    @(posedge clk); #1;
    p1(E_RST, "reset_held");
    drain("reset");
    rst1 = 1'b1;
    p1(E_RST, "cycle0");
    drain("release");

    // add
    op1 = 6'h00; fn1 = 6'h20;
    p1(E_F, "add_fetch1"); p1(E_FF, "add_fetch2"); p1(E_DEC, "add_decode");
    p1(E_EXR, "add_exec"); p1(E_WBR, "add_wb");
    drain("add");

    // addi
    op1 = 6'h08;
    p1(E_F, "addi_fetch1"); p1(E_FF, "addi_fetch2"); p1(E_DEC, "addi_decode");
    p1(E_EXI, "addi_exec"); p1(E_WBI, "addi_wb");
    drain("addi");

    // lw: 7 cycles, MDR_w only in second MEM_RD cycle
    op1 = 6'h23;
    p1(E_F, "lw_fetch1"); p1(E_FF, "lw_fetch2"); p1(E_DEC, "lw_decode");
    p1(E_ADR, "lw_addr"); p1(E_MRD, "lw_mrd1"); p1(E_MRDF, "lw_mrd2"); p1(E_WBM, "lw_wb");
    drain("lw");

    // sw
    op1 = 6'h2B;
    p1(E_F, "sw_fetch1"); p1(E_FF, "sw_fetch2"); p1(E_DEC, "sw_decode");
    p1(E_ADR, "sw_addr"); p1(E_MWR, "sw_memwr");
    drain("sw");

    // beq taken / not taken
    op1 = 6'h04; zero1 = 1'b1;
    p1(E_F, "beqz_fetch1"); p1(E_FF, "beqz_fetch2"); p1(E_DEC, "beqz_decode");
    p1(E_BR1, "beqz_branch");
    drain("beq_taken");
    zero1 = 1'b0;
    p1(E_F, "beqn_fetch1"); p1(E_FF, "beqn_fetch2"); p1(E_DEC, "beqn_decode");
    p1(E_BR0, "beqn_branch");
    drain("beq_not_taken");

    // j then fetch proves return to FETCH after branch/jump
    op1 = 6'h02;
    p1(E_F, "j_fetch1"); p1(E_FF, "j_fetch2"); p1(E_DEC, "j_decode");
    p1(E_JMP, "j_jump"); p1(E_F, "j_refetch");
    drain("j");
    // queue drained at cycle 2 of this FETCH: continue with FETCH final
    op1 = 6'h3F;
    p1(E_FF, "ill_fetch2"); p1(E_DEC, "ill_decode");
    for (int i = 0; i < 20; i++) p1(E_HLT, "halt_hold");
    drain("illegal");
    reset1_cycle("halt_reset");

    // R-type with unsupported FUNCT traps too
    op1 = 6'h00; fn1 = 6'h22;
    p1(E_F, "badfn_fetch1"); p1(E_FF, "badfn_fetch2"); p1(E_DEC, "badfn_decode");
    p1(E_HLT, "badfn_halt"); p1(E_HLT, "badfn_halt2");
    drain("bad_funct");
    reset1_cycle("badfn_reset");

    // MEM_WAIT = 0 instance: j
    rst0 = 1'b1;
    op0 = 6'h02;
    p0(E_RST, "w0_cycle0"); p0(E_FF, "w0_j_fetch"); p0(E_DEC, "w0_j_decode");
    p0(E_JMP, "w0_j_jump");
    drain("w0_j");

    // lw with no wait: 5 cycles
    op0 = 6'h23;
    p0(E_FF, "w0_lw_fetch"); p0(E_DEC, "w0_lw_decode"); p0(E_ADR, "w0_lw_addr");
    p0(E_MRDF, "w0_lw_mrd"); p0(E_WBM, "w0_lw_wb");
    drain("w0_lw");

    // sw, aborted by reset in MEM_WR
    op0 = 6'h2B;
    p0(E_FF, "w0_sw_fetch"); p0(E_DEC, "w0_sw_decode"); p0(E_ADR, "w0_sw_addr");
    drain("w0_sw");
    chk("w0_memwr_entered", {3'b0, memw0, st0}, {3'b0, 1'b1, 4'd10});
    rst0 = 1'b0;
    #1;
    chk("w0_memwr_abort", {3'b0, memw0, st0}, 8'h00);
    p0(E_RST, "w0_abort_held");
    drain("w0_abort");
    rst0 = 1'b1;
    p0(E_RST, "w0_abort_cycle0"); p0(E_FF, "w0_after_fetch");
    drain("w0_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
